cam_sdram_wr_burst: RTL and testbench
=====================================

Name: cam_sdram_wr_burst

Overview:
- Downstream consumer of the camera byte-to-word combiner.
- Buffers 32-bit packed pixel-pair words in a local FIFO and issues fixed-length burst write requests to the SDRAM controller write port.
- Generates linear frame addresses, with a shorter tail burst at end of frame.
- Restarts the frame on the combiner's frame-reset pulse; flags frame completion and FIFO overflow.

Parameters:
- ADDR_W, 22, SDRAM word address width.
- BURST_LEN, 64, words per full burst (power of 2, ≤ FIFO_DEPTH/2).
- FIFO_DEPTH, 256, local FIFO depth in words (power of 2).
- FRAME_WORDS, 153600, words per frame (640x480 / 2 pixels per word).
- BASE_ADDR, 0, frame buffer start address.
- BANK_OFFSET, 'h40000, address distance between ping-pong banks (optional feature only).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cam_data_rst  in  1  frame restart; level, multi-cycle.
- i_cam_data_valid  in  1  one word strobe.
- i_cam_data_32  in  32  packed pixel pair.
- o_wr_req  out  1  burst request.
- i_wr_ack  in  1  one-cycle request acceptance.
- o_wr_addr  out  ADDR_W  burst start word address.
- o_wr_len  out  $clog2(BURST_LEN)+1  burst length in words.
- i_wr_data_req  in  1  controller pops one word this cycle.
- o_wr_data  out  32  FIFO head (first-word-fall-through).
- o_frame_done  out  1  one-cycle pulse, last word of frame popped.
- o_overflow  out  1  sticky, word dropped because FIFO full.
- o_wr_bank  out  1  bank being written (tied 0 without feature).

Behaviour:
- Reset values: all outputs 0; FIFO empty; counters 0; state IDLE.
- Input side:
  - Word accepted when valid, not full, in_cnt < FRAME_WORDS, and no restart pending.
  - Valid while FIFO full: word dropped, o_overflow <= 1.
  - Words beyond FRAME_WORDS: silently dropped, not counted as overflow.
- FSM states: IDLE, REQ, DATA, FRAME_END.
- IDLE -> REQ when fifo_cnt ≥ BURST_LEN, or fifo_cnt ≥ remain where remain = FRAME_WORDS - out_cnt < BURST_LEN.
  - On entry: len = min(BURST_LEN, remain); o_wr_addr = BASE_ADDR + bank*BANK_OFFSET + out_cnt.
- REQ: o_wr_req = 1; addr and len held stable until i_wr_ack; ack -> DATA (o_wr_req low the next cycle).
- DATA: each i_wr_data_req pops one word; o_wr_data is valid combinationally whenever FIFO is non-empty.
  - After len pops: out_cnt += len.
  - If out_cnt reaches FRAME_WORDS -> FRAME_END, else -> IDLE.
- FRAME_END: o_frame_done pulses 1 cycle; waits for i_cam_data_rst, then -> IDLE.
- i_cam_data_rst in IDLE or FRAME_END:
  - Flushes FIFO and clears in_cnt/out_cnt.
  - Clears o_overflow.
  - Address restarts at bank base.
- i_cam_data_rst during REQ/DATA: latched as pending.
  - Current burst completes in full; the words are already in the FIFO by the request condition.
  - Input is ignored while pending.
  - Flush happens on the return to IDLE.
- i_wr_data_req with FIFO empty, or outside DATA: protocol error; ignored, no pop (bench assertion).
- Simultaneous push and pop on the same cycle: fifo_cnt unchanged.
- Asynchronous i_rst_n mid-burst: immediate return to reset values; o_wr_req drops at once.

Optional Feature:
- Macro: CAM_WR_PINGPONG_EN.
- Defined:
  - Bank register toggles in the cycle o_frame_done pulses; o_wr_bank = bank.
  - Address = BASE_ADDR + bank*BANK_OFFSET + offset.
  - A frame aborted by restart before completion does not toggle the bank.
  - The reader uses ~o_wr_bank.
- Undefined: bank constant 0; o_wr_bank tied 0; BANK_OFFSET unused.

Decomposition:
- Package cam_wr_pkg:
  - state enum typedef (IDLE, REQ, DATA, FRAME_END).
  - CAM_WORD_W = 32.
  - Length/address width helper functions.
- Sub-module sync_fifo_fwft: single-clock, async active-low reset, synchronous flush input, count/full/empty outputs, first-word-fall-through read.

Test Plan:
- Bench settings: FRAME_WORDS=200, BURST_LEN=64, FIFO_DEPTH=256.
- Steady frame, 200 valid words, controller acks after 3 cycles and pops continuously:
  - Bursts (addr, len) = (0,64), (64,64), (128,64), (192,8).
  - o_frame_done pulses once after the 200th pop; data order matches input.
- Controller stalls (no ack) with 300 words offered: exactly 256 stored, 44 dropped, o_overflow = 1; next i_cam_data_rst clears it to 0.
- Restart asserted 5 cycles into a DATA burst:
  - Burst still delivers all 64 words; FIFO is flushed afterwards.
  - Next request is at addr 0 (bank unchanged).
- 210 words in one frame: words 201–210 dropped; o_overflow stays 0; no burst issued beyond the frame.
- Push and pop on the same cycle at fifo_cnt = 64: count stays 64; i_rst_n pulsed low mid-REQ gives all outputs 0 immediately.
- With CAM_WR_PINGPONG_EN, two complete frames:
  - Frame 1 addresses from 0, frame 2 from 'h40000.
  - o_wr_bank toggles 0→1 when frame 1's o_frame_done pulses.

Source files
------------

// File: rtl/cam_wr_pkg.sv
// cam_wr_pkg: shared state encoding, word width and width helpers for the camera SDRAM burst writer
package cam_wr_pkg;
  localparam int CAM_WORD_W = 32;
  typedef enum logic [1:0] {IDLE, REQ, DATA, FRAME_END} state_t;
  function automatic int len_w(input int burst);
    return $clog2(burst) + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with synchronous flush
module sync_fifo_fwft #(
  parameter int W = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  // status flags, guarded push/pop and the fall-through head word
  always_comb begin
    full = cnt == (AW+1)'(DEPTH);
    empty = cnt == '0;
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    dout = mem[rp];
  end
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  // pointers and occupancy; a simultaneous push and pop leaves cnt unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cam_sdram_wr_burst.sv
// cam_sdram_wr_burst: buffers camera words and issues linear SDRAM burst writes; CAM_WR_PINGPONG_EN adds bank ping-pong
module cam_sdram_wr_burst
  import cam_wr_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int BURST_LEN = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int FRAME_WORDS = 153600,
  parameter int BASE_ADDR = 0,
  parameter int BANK_OFFSET = 'h40000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cam_data_rst,
  input  logic                         i_cam_data_valid,
  input  logic [CAM_WORD_W-1:0]        i_cam_data_32,
  output logic                         o_wr_req,
  input  logic                         i_wr_ack,
  output logic [ADDR_W-1:0]            o_wr_addr,
  output logic [len_w(BURST_LEN)-1:0]  o_wr_len,
  input  logic                         i_wr_data_req,
  output logic [CAM_WORD_W-1:0]        o_wr_data,
  output logic                         o_frame_done,
  output logic                         o_overflow,
  output logic                         o_wr_bank
);
  localparam int CW = cnt_w(FRAME_WORDS);
  localparam int LW = len_w(BURST_LEN);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  state_t state;
  logic [CW-1:0] in_cnt, out_cnt;
  logic [LW-1:0] pop_cnt;
  logic [FW-1:0] fifo_cnt;
  logic [31:0] remain;
  logic full, empty, pend, bank, flush, take, push, drop, pop, last, end_next, start;
  sync_fifo_fwft #(.W(CAM_WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .flush(flush), .push(push), .pop(pop),
    .din(i_cam_data_32), .dout(o_wr_data), .cnt(fifo_cnt), .full(full), .empty(empty)
  );
  // restart flushes only between bursts; input is blocked while a restart is outstanding
  always_comb begin
    remain = 32'(FRAME_WORDS) - 32'(out_cnt);
    flush = (state == IDLE || state == FRAME_END) && (i_cam_data_rst || pend);
    take = i_cam_data_valid && in_cnt < CW'(FRAME_WORDS) && !pend && !i_cam_data_rst;
    push = take && !full;
    drop = take && full;
    pop = i_wr_data_req && state == DATA && !empty;
    last = pop && pop_cnt + LW'(1) == o_wr_len;
    end_next = 32'(out_cnt) + 32'(o_wr_len) == 32'(FRAME_WORDS);
    start = state == IDLE && !flush &&
            (32'(fifo_cnt) >= 32'(BURST_LEN) || (remain < 32'(BURST_LEN) && 32'(fifo_cnt) >= remain));
    o_wr_req = state == REQ;
    o_wr_bank = bank;
  end
`ifdef CAM_WR_PINGPONG_EN
  // bank flips together with the frame-done pulse so the reader can take the other one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bank <= 1'b0;
    else if (last && end_next) bank <= ~bank;
  end
`else
  assign bank = 1'b0;
`endif
  // burst sequencing, frame counters, restart latch and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      in_cnt <= '0;
      out_cnt <= '0;
      pop_cnt <= '0;
      pend <= 1'b0;
      o_wr_addr <= '0;
      o_wr_len <= '0;
      o_frame_done <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      in_cnt <= flush ? '0 : in_cnt + CW'(push);
      o_overflow <= !flush && (o_overflow || drop);
      pend <= !flush && (pend || (i_cam_data_rst && (state == REQ || state == DATA)));
      o_frame_done <= last && end_next;
      if (flush) out_cnt <= '0;
      case (state)
        IDLE: if (start) begin
          state <= REQ;
          o_wr_len <= remain < 32'(BURST_LEN) ? LW'(remain) : LW'(BURST_LEN);
          o_wr_addr <= ADDR_W'(BASE_ADDR) + (bank ? ADDR_W'(BANK_OFFSET) : '0) + ADDR_W'(out_cnt);
        end
        REQ: if (i_wr_ack) begin
          state <= DATA;
          pop_cnt <= '0;
        end
        DATA: if (last) begin
          out_cnt <= out_cnt + CW'(o_wr_len);
          state <= end_next ? FRAME_END : IDLE;
        end else if (pop) pop_cnt <= pop_cnt + LW'(1);
        default: if (flush) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_sdram_wr_burst.sv
// tb_cam_sdram_wr_burst: directed checks of bursts, restart, overflow, push/pop and async reset
module tb_cam_sdram_wr_burst;
`ifdef CAM_WR_PINGPONG_EN
  localparam logic [21:0] B1 = 22'h40000;
  localparam logic PP = 1'b1;
`else
  localparam logic [21:0] B1 = 22'h0;
  localparam logic PP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0, crst = 1'b0, cval = 1'b0, ack = 1'b0, dreq = 1'b0;
  logic [31:0] cdata = '0;
  logic req, done, ovf, bank;
  logic [21:0] addr;
  logic [6:0] len;
  logic [31:0] wdata;
  logic rst2_n = 1'b0, crst2 = 1'b0, cval2 = 1'b0, ack2 = 1'b0, dreq2 = 1'b0;
  logic [31:0] cdata2 = '0;
  logic req2, done2, ovf2, bank2;
  logic [21:0] addr2;
  logic [6:0] len2;
  logic [31:0] wdata2;
  int n_cmp = 0, n_err = 0;
  int nb, ndone, derr, last_pop, done_cyc;
  logic [21:0] baddr [8];
  logic [6:0] blen [8];

  always #5 clk = ~clk;

  cam_sdram_wr_burst #(.FRAME_WORDS(200), .BURST_LEN(64), .FIFO_DEPTH(256)) d (
    .i_clk(clk), .i_rst_n(rst_n), .i_cam_data_rst(crst), .i_cam_data_valid(cval),
    .i_cam_data_32(cdata), .o_wr_req(req), .i_wr_ack(ack), .o_wr_addr(addr), .o_wr_len(len),
    .i_wr_data_req(dreq), .o_wr_data(wdata), .o_frame_done(done), .o_overflow(ovf), .o_wr_bank(bank)
  );

  cam_sdram_wr_burst #(.FRAME_WORDS(1000), .BURST_LEN(64), .FIFO_DEPTH(256)) o (
    .i_clk(clk), .i_rst_n(rst2_n), .i_cam_data_rst(crst2), .i_cam_data_valid(cval2),
    .i_cam_data_32(cdata2), .o_wr_req(req2), .i_wr_ack(ack2), .o_wr_addr(addr2), .o_wr_len(len2),
    .i_wr_data_req(dreq2), .o_wr_data(wdata2), .o_frame_done(done2), .o_overflow(ovf2), .o_wr_bank(bank2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int nwords, input int seed, input int ncyc);
    int i = 0, wait_c = 0, rem = 0, popped = 0;
    nb = 0; ndone = 0; derr = 0; last_pop = -1; done_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      ack = 1'b0; dreq = 1'b0; cval = 1'b0;
      if (done) begin ndone++; done_cyc = c; end
      if (rem > 0) begin
        dreq = 1'b1;
        if (wdata !== 32'(seed + popped)) derr++;
        popped++; rem--; last_pop = c;
      end else if (req) begin
        wait_c++;
        if (wait_c == 3) begin
          ack = 1'b1;
          if (nb < 8) begin baddr[nb] = addr; blen[nb] = len; end
          nb++; rem = int'(len); wait_c = 0;
        end
      end
      if (i < nwords) begin cval = 1'b1; cdata = 32'(seed + i); i++; end
      tick;
    end
    ack = 1'b0; dreq = 1'b0; cval = 1'b0;
  endtask

  task automatic restart;
    crst = 1'b1;
    repeat (3) tick;
    crst = 1'b0;
    tick;
  endtask

  task automatic frame_checks(input string f, input logic [21:0] base);
    check({f, " bursts"}, 64'(nb), 4);
    check({f, " b0 addr"}, 64'(baddr[0]), 64'(base));
    check({f, " b0 len"}, 64'(blen[0]), 64);
    check({f, " b1 addr"}, 64'(baddr[1]), 64'(base + 22'd64));
    check({f, " b2 addr"}, 64'(baddr[2]), 64'(base + 22'd128));
    check({f, " b3 addr"}, 64'(baddr[3]), 64'(base + 22'd192));
    check({f, " b3 len"}, 64'(blen[3]), 8);
    check({f, " done count"}, 64'(ndone), 1);
    check({f, " done timing"}, 64'(done_cyc), 64'(last_pop + 1));
    check({f, " data order"}, 64'(derr), 0);
  endtask

  initial begin
    repeat (3) tick;
    check("reset req", 64'(req), 0);
    check("reset addr", 64'(addr), 0);
    check("reset len", 64'(len), 0);
    check("reset done", 64'(done), 0);
    check("reset ovf", 64'(ovf), 0);
    check("reset bank", 64'(bank), 0);
    rst_n = 1'b1; rst2_n = 1'b1;
    tick;
    run(200, 1000, 400);
    frame_checks("f1", 22'h0);
    check("f1 bank after", 64'(bank), 64'(PP));
    restart;
    run(200, 2000, 400);
    frame_checks("f2", B1);
    restart;
    run(210, 3000, 400);
    frame_checks("f3", 22'h0);
    check("f3 no ovf", 64'(ovf), 0);
    check("f3 no extra req", 64'(req), 0);
    restart;
    for (int k = 0; k < 100; k++) begin cval = 1'b1; cdata = 32'(4000 + k); tick; end
    cval = 1'b0;
    check("f4 req", 64'(req), 1);
    check("f4 addr", 64'(addr), 64'(B1));
    ack = 1'b1; tick; ack = 1'b0;
    derr = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 5) crst = 1'b1;
      cval = k >= 5; cdata = 32'd9999;
      dreq = 1'b1;
      if (wdata !== 32'(4000 + k)) derr++;
      tick;
    end
    dreq = 1'b0; cval = 1'b0;
    tick;
    check("rst mid burst data", 64'(derr), 0);
    check("rst mid burst no req", 64'(req), 0);
    crst = 1'b0;
    tick; tick;
    check("flush fifo cnt", 64'(d.u_fifo.cnt), 0);
    for (int k = 0; k < 64; k++) begin cval = 1'b1; cdata = 32'(5000 + k); tick; end
    cval = 1'b0;
    tick;
    check("post flush req", 64'(req), 1);
    check("post flush addr", 64'(addr), 64'(B1));
    check("post flush head", 64'(wdata), 5000);
    ack = 1'b1; tick; ack = 1'b0;
    for (int k = 0; k < 64; k++) begin
      dreq = 1'b1; cval = 1'b1; cdata = 32'(6000 + k);
      tick;
      if (k == 0) check("push+pop cnt", 64'(d.u_fifo.cnt), 64);
    end
    dreq = 1'b0; cval = 1'b0;
    tick; tick;
    check("next req", 64'(req), 1);
    check("next addr", 64'(addr), 64'(B1 + 22'd64));
    check("next head", 64'(wdata), 6000);
    #2 rst_n = 1'b0;
    #1;
    check("async rst req", 64'(req), 0);
    check("async rst addr", 64'(addr), 0);
    check("async rst len", 64'(len), 0);
    check("async rst done", 64'(done), 0);
    check("async rst ovf", 64'(ovf), 0);
    check("async rst bank", 64'(bank), 0);
    tick;
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 300; k++) begin cval2 = 1'b1; cdata2 = 32'(k); tick; end
    cval2 = 1'b0;
    check("ovf set", 64'(ovf2), 1);
    check("ovf stored", 64'(o.u_fifo.cnt), 256);
    check("ovf req", 64'(req2), 1);
    check("ovf addr", 64'(addr2), 0);
    check("ovf len", 64'(len2), 64);
    dreq2 = 1'b1; tick; dreq2 = 1'b0;
    check("stray pop cnt", 64'(o.u_fifo.cnt), 256);
    check("stray pop head", 64'(wdata2), 0);
    crst2 = 1'b1; tick;
    check("ovf held while pending", 64'(ovf2), 1);
    ack2 = 1'b1; tick; ack2 = 1'b0;
    derr = 0;
    for (int k = 0; k < 64; k++) begin
      dreq2 = 1'b1;
      if (wdata2 !== 32'(k)) derr++;
      tick;
    end
    dreq2 = 1'b0;
    tick; tick;
    check("ovf burst data", 64'(derr), 0);
    check("ovf cleared", 64'(ovf2), 0);
    check("ovf fifo flushed", 64'(o.u_fifo.cnt), 0);
    crst2 = 1'b0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
